// File: rtl/lcd_responder.sv
// Device-side model of an HD44780-style 16x2 character LCD bus.
// Ops execute on the EN falling edge into a 32-byte DDRAM mirror.
module lcd_responder #(
  parameter int BUSY_CYC = 2000,
  parameter int CLR_CYC  = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       RW,
  input  logic       RS,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [4:0] cursor,
  output logic       two_line,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_strobe,
  output logic       char_strobe,
  output logic       overrun,
  output logic       err_unsup
);

  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYC - 1);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLR_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      fill_q, fill_d;
  logic [4:0]      cur_q, cur_d;
  logic            incr_q, incr_d;
  logic            two_q, two_d;
  logic            disp_q, disp_d;
  logic            curs_q, curs_d;
  logic            blink_q, blink_d;
  logic            err_q, err_d;
  logic            cmd_q, cmd_d;
  logic            chr_q, chr_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      dout_q, dout_d;
  logic            en_q, rw_q, rs_q;
  logic [7:0]      d_q;
  logic [7:0]      mem_q [32];

  logic            fall;
  logic [4:0]      step;
  logic            we;
  logic [4:0]      wa;
  logic [7:0]      wd;

  assign fall = en_q & ~EN;
  assign step = incr_q ? cur_q + 5'd1 : cur_q - 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    cur_d   = cur_q;
    incr_d  = incr_q;
    two_d   = two_q;
    disp_d  = disp_q;
    curs_d  = curs_q;
    blink_d = blink_q;
    err_d   = err_q;
    cmd_d   = 1'b0;
    chr_d   = 1'b0;
    ovr_d   = 1'b0;
    we      = 1'b0;
    wa      = cur_q;
    wd      = d_q;
    unique case (state_q)
      IDLE: if (fall) begin
        if (rw_q) begin
          if (rs_q) cur_d = step;
        end else if (rs_q) begin
          we      = 1'b1;
          cur_d   = step;
          chr_d   = 1'b1;
          state_d = BUSY;
          cnt_d   = BUSY_LD;
        end else begin
          cmd_d   = 1'b1;
          state_d = BUSY;
          cnt_d   = BUSY_LD;
          unique casez (d_q)
            8'b1???????: begin
              cur_d = {d_q[6], d_q[3:0]};
              if (d_q[5:4] != 2'b00) err_d = 1'b1;
            end
            8'b01??????: err_d = 1'b1;
            8'b001?????: begin
              two_d = d_q[3];
              if (!d_q[4]) err_d = 1'b1;
            end
            8'b0001????: begin
              if (d_q[3]) err_d = 1'b1;
              else if (d_q[2]) cur_d = cur_q + 5'd1;
              else cur_d = cur_q - 5'd1;
            end
            8'b00001???: {disp_d, curs_d, blink_d} = d_q[2:0];
            8'b000001??: begin
              incr_d = d_q[1];
              if (d_q[0]) err_d = 1'b1;
            end
            8'b0000001?: begin
              cur_d = 5'd0;
              cnt_d = CLR_LD;
            end
            8'b00000001: begin
              cur_d   = 5'd0;
              incr_d  = 1'b1;
              cnt_d   = CLR_LD;
              fill_d  = 5'd0;
              state_d = FILL;
            end
            default: ;
          endcase
        end
      end
      FILL: begin
        ovr_d  = fall;
        we     = 1'b1;
        wa     = fill_q;
        wd     = 8'h20;
        fill_d = fill_q + 5'd1;
        cnt_d  = cnt_q - CW'(1);
        if (fill_q == 5'd31) state_d = BUSY;
      end
      BUSY: begin
        ovr_d = fall;
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data tracks the bus while a read strobe is held.
  always_comb begin
    dout_d = dout_q;
    if (EN && RW) begin
      if (RS) dout_d = mem_q[cur_q];
      else dout_d = {busy, cur_q[4], 2'b00, cur_q[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= 5'd0;
      cur_q   <= 5'd0;
      incr_q  <= 1'b1;
      two_q   <= 1'b0;
      disp_q  <= 1'b0;
      curs_q  <= 1'b0;
      blink_q <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= 1'b0;
      chr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= 8'h00;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else begin
      en_q    <= EN;
      rw_q    <= RW;
      rs_q    <= RS;
      d_q     <= data_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      cur_q   <= cur_d;
      incr_q  <= incr_d;
      two_q   <= two_d;
      disp_q  <= disp_d;
      curs_q  <= curs_d;
      blink_q <= blink_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      chr_q   <= chr_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      if (we) mem_q[wa] <= wd;
    end
  end

  assign busy        = (state_q != IDLE);
  assign data_oe     = EN & RW;
  assign data_out    = dout_q;
  assign cursor      = cur_q;
  assign two_line    = two_q;
  assign display_on  = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign rd_char     = mem_q[rd_addr];
  assign cmd_strobe  = cmd_q;
  assign char_strobe = chr_q;
  assign overrun     = ovr_q;
  assign err_unsup   = err_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed self-checking bench for lcd_responder.
// Short busy timings keep the run well inside the cycle budget.
module tb_lcd_responder;

  localparam int BCYC = 20;
  localparam int CCYC = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       EN = 1'b0;
  logic       RW = 1'b0;
  logic       RS = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;
  logic [4:0] cursor;
  logic       two_line;
  logic       display_on;
  logic       cursor_on;
  logic       blink_on;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       cmd_strobe;
  logic       char_strobe;
  logic       overrun;
  logic       err_unsup;

  int total = 0;
  int bad = 0;
  int n_cmd = 0;
  int n_chr = 0;
  int n_ovr = 0;

  lcd_responder #(.BUSY_CYC(BCYC), .CLR_CYC(CCYC)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .RW(RW), .RS(RS),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .busy(busy), .cursor(cursor), .two_line(two_line),
    .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .rd_addr(rd_addr), .rd_char(rd_char),
    .cmd_strobe(cmd_strobe), .char_strobe(char_strobe),
    .overrun(overrun), .err_unsup(err_unsup)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmd += int'(cmd_strobe);
      n_chr += int'(char_strobe);
      n_ovr += int'(overrun);
    end
  end

  // Ends on the negedge right after the posedge that sees the fall.
  task automatic bus_op(input logic rw, input logic rs, input logic [7:0] d);
    @(negedge clk);
    RW = rw; RS = rs; data_in = d; EN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    EN = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s idle-timeout busy=%0b want 0", tag, busy);
    end
  endtask

  task automatic check_blank(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      total++;
      if (rd_char !== 8'h20) begin
        bad++;
        $display("FAIL %s ddram[%0d]=%h want 20", tag, i, rd_char);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, cursor, err_unsup, data_out} !== 15'd0) begin
      bad++;
      $display("FAIL reset_regs busy=%b cur=%0d err=%b dout=%h want 0",
               busy, cursor, err_unsup, data_out);
    end
    total++;
    if ({two_line, display_on, cursor_on, blink_on} !== 4'd0) begin
      bad++;
      $display("FAIL reset_flags got=%b want 0000",
               {two_line, display_on, cursor_on, blink_on});
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_blank("reset_ddram");
  endtask

  task automatic test_init;
    int n;
    int c0;
    c0 = n_cmd;
    bus_op(1'b0, 1'b0, 8'h38); wait_idle("fs");
    bus_op(1'b0, 1'b0, 8'h0E); wait_idle("dc");
    bus_op(1'b0, 1'b0, 8'h01);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== CCYC) begin
      bad++;
      $display("FAIL clr_busy_len got=%0d want %0d", n, CCYC);
    end
    bus_op(1'b0, 1'b0, 8'h02); wait_idle("home");
    bus_op(1'b0, 1'b0, 8'h06); wait_idle("em");
    total++;
    if ({two_line, display_on, cursor_on, blink_on} !== 4'b1110) begin
      bad++;
      $display("FAIL init_flags got=%b want 1110",
               {two_line, display_on, cursor_on, blink_on});
    end
    total++;
    if (err_unsup !== 1'b0 || cursor !== 5'd0) begin
      bad++;
      $display("FAIL init_state err=%b cur=%0d want 0 0", err_unsup, cursor);
    end
    total++;
    if (n_cmd - c0 !== 5) begin
      bad++;
      $display("FAIL init_cmd_strobes got=%0d want 5", n_cmd - c0);
    end
  endtask

  task automatic test_chars;
    logic [7:0] s [4];
    int c0;
    s[0] = 8'h41; s[1] = 8'h44; s[2] = 8'h44; s[3] = 8'h49;
    c0 = n_chr;
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, 1'b1, s[i]);
      wait_idle("chr");
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 5'(i);
      #1;
      total++;
      if (rd_char !== s[i]) begin
        bad++;
        $display("FAIL chars ddram[%0d]=%h want %h", i, rd_char, s[i]);
      end
    end
    total++;
    if (cursor !== 5'd4 || n_chr - c0 !== 4) begin
      bad++;
      $display("FAIL chars_cur cur=%0d strobes=%0d want 4 4",
               cursor, n_chr - c0);
    end
  endtask

  task automatic test_wrap;
    bus_op(1'b0, 1'b0, 8'hCF); wait_idle("addr");
    total++;
    if (cursor !== 5'd31) begin
      bad++;
      $display("FAIL set_addr cur=%0d want 31", cursor);
    end
    bus_op(1'b0, 1'b1, 8'h58); wait_idle("w31");
    rd_addr = 5'd31;
    #1;
    total++;
    if (rd_char !== 8'h58 || cursor !== 5'd0) begin
      bad++;
      $display("FAIL wrap_up ddram31=%h cur=%0d want 58 0", rd_char, cursor);
    end
    bus_op(1'b0, 1'b0, 8'h04); wait_idle("dec");
    bus_op(1'b0, 1'b1, 8'h2B); wait_idle("w0");
    rd_addr = 5'd0;
    #1;
    total++;
    if (rd_char !== 8'h2B || cursor !== 5'd31) begin
      bad++;
      $display("FAIL wrap_down ddram0=%h cur=%0d want 2B 31", rd_char, cursor);
    end
  endtask

  task automatic test_overrun_reset;
    int o0;
    o0 = n_ovr;
    bus_op(1'b0, 1'b0, 8'h01);
    bus_op(1'b0, 1'b1, 8'h5A);
    wait_idle("clr2");
    total++;
    if (n_ovr - o0 !== 1) begin
      bad++;
      $display("FAIL overrun_cnt got=%0d want 1", n_ovr - o0);
    end
    total++;
    if (cursor !== 5'd0 || n_chr !== 6) begin
      bad++;
      $display("FAIL overrun_drop cur=%0d chars=%0d want 0 6", cursor, n_chr);
    end
    check_blank("clr_ddram");
    bus_op(1'b0, 1'b0, 8'h02);
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL async_abort busy=%b want 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_err;
    bus_op(1'b0, 1'b0, 8'hC5);
    RW = 1'b1; RS = 1'b0; EN = 1'b1;
    @(negedge clk);
    total++;
    if (data_out !== 8'hC5 || data_oe !== 1'b1) begin
      bad++;
      $display("FAIL rd_busy dout=%h oe=%b want C5 1", data_out, data_oe);
    end
    wait_idle("rd");
    @(negedge clk);
    total++;
    if (data_out !== 8'h45) begin
      bad++;
      $display("FAIL rd_idle dout=%h want 45", data_out);
    end
    EN = 1'b0;
    @(negedge clk);
    total++;
    if (data_oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_end oe=%b busy=%b want 0 0", data_oe, busy);
    end
    bus_op(1'b0, 1'b0, 8'h1C); wait_idle("dshift");
    total++;
    if (err_unsup !== 1'b1 || cursor !== 5'd21) begin
      bad++;
      $display("FAIL err_set err=%b cur=%0d want 1 21", err_unsup, cursor);
    end
    bus_op(1'b0, 1'b0, 8'h38); wait_idle("fs2");
    total++;
    if (err_unsup !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky err=%b want 1", err_unsup);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_chars;
    test_wrap;
    test_overrun_reset;
    test_read_err;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
